i2c_txn_arbiter: RTL
====================

Name: i2c_txn_arbiter

Overview:
- Shares one byte-level I2C register-access engine (START / device address / register address / repeated START / data / STOP) between NUM_REQ requesters.
- Round-robin arbitration; latches the winner's transaction fields and launches the engine.
- Supervises completion with a timeout and returns read data, status and a per-requester done pulse.
- Sits between sensor-polling/config logic and the I2C master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 1023, clk cycles allowed from eng_start to eng_done before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until gnt seen, dropped the cycle after
req_dev_addr  in  7*NUM_REQ  7-bit slave address, slice i = [7i+6:7i]
req_reg_addr  in  8*NUM_REQ  register address, slice i = [8i+7:8i]
req_rw  in  NUM_REQ  1=read, 0=write
req_wdata  in  8*NUM_REQ  write byte
gnt  out  NUM_REQ  one-hot accept pulse, 1 cycle
done  out  NUM_REQ  one-hot completion pulse, 1 cycle
rdata  out  8  last successfully read byte
err  out  1  status of last completed txn (1 = NACK or timeout)
eng_start  out  1  launch pulse, 1 cycle
eng_dev_addr  out  7  latched slave address
eng_reg_addr  out  8  latched register address
eng_rw  out  1  latched direction
eng_wdata  out  8  latched write byte
eng_abort  out  1  1-cycle pulse on timeout; engine returns SDA/SCL to idle
eng_busy  in  1  engine not ready
eng_done  in  1  1-cycle completion from engine
eng_rdata  in  8  byte read by engine, valid with eng_done
eng_nack  in  1  any ACK slot saw NACK, valid with eng_done

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, rr pointer 0, timeout counter 0. Takes effect immediately, including mid-transaction; no done is emitted for a cut transaction. Engine shares the same reset.
- States:
  - IDLE: on the clk edge where req!=0 and eng_busy==0:
    - Winner w = first set req bit searching from ptr upward, wrapping.
    - Latch w's fields into eng_* registers.
    - Next cycle: gnt[w]=1 and eng_start=1 together (latency 1 cycle from sampled req).
    - ptr <= (w+1) mod NUM_REQ; counter <= 0; go to WAIT.
    - If eng_busy=1, no grant; req is held.
  - WAIT: counter increments each cycle.
    - If eng_done: done[w]=1 next cycle; err <= eng_nack; rdata <= eng_rdata only if eng_rw=1 and eng_nack=0, else rdata holds. Go to RESP.
    - Else if counter == TIMEOUT_CYC-1: done[w]=1, err=1, eng_abort=1 next cycle; rdata holds. Go to RESP.
    - eng_done and timeout in the same cycle: eng_done wins (normal completion).
  - RESP: 1 guard cycle (done/eng_abort pulse visible), then IDLE. Minimum spacing between two eng_start pulses = 3 cycles + engine time.
- eng_done or eng_nack while in IDLE or RESP is ignored.
- eng_* field outputs hold their values until the next grant.
- err and rdata persist until the next completion.
- req changes while in WAIT/RESP have no effect until IDLE.
- Counter width = clog2(TIMEOUT_CYC+1); no wrap.
- Winner index registered; gnt and done are always one-hot or zero.

Test Plan:
- Read, req[0] only (dev 0x29, reg 0x77, rw=1); engine asserts eng_done 20 cycles after start with eng_rdata=0xAA, nack=0 -> gnt=0001 and eng_start same cycle with eng_dev_addr=0x29/eng_reg_addr=0x77; done=0001 1 cycle after eng_done; rdata=0xAA; err=0.
- After reset, req=1111 held continuously, each requester drops req after its gnt -> grants in order 0,1,2,3; exactly 4 eng_start pulses, each paired with the matching done.
- Fairness: req[0] and req[2] re-asserted immediately after each done -> grants alternate 0,2,0,2 over 8 transactions.
- NACK: write txn, req[1], wdata=0x5A; engine returns eng_done with eng_nack=1 -> done=0010, err=1, rdata unchanged from its prior 0xAA.
- Timeout: TIMEOUT_CYC=16, engine never asserts done -> done[w] and eng_abort pulse together, 16 cycles after eng_start; err=1; a following grant proceeds normally. eng_done on the terminal cycle instead -> err=0, no eng_abort.
- Reset low for 3 cycles mid-WAIT -> all outputs 0 immediately, no done pulse; after release with req=0100, grant goes to requester 2 with ptr restarted from 0.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C register-access engine between NUM_REQ
// requesters, latches the winner's transaction, and supervises completion with a timeout.
module i2c_txn_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_dev_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 eng_start,
  output logic [6:0]           eng_dev_addr,
  output logic [7:0]           eng_reg_addr,
  output logic                 eng_rw,
  output logic [7:0]           eng_wdata,
  output logic                 eng_abort,
  input  logic                 eng_busy,
  input  logic                 eng_done,
  input  logic [7:0]           eng_rdata,
  input  logic                 eng_nack
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     win_q, win_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic [6:0]          dev_q, dev_d;
  logic [7:0]          reg_q, reg_d;
  logic                rw_q, rw_d;
  logic [7:0]          wdata_q, wdata_d;

  // Rotating priority search starting at ptr_q.
  logic [PtrW-1:0] win_idx;
  logic [PtrW-1:0] cand;
  logic            win_found;
  int unsigned     idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(ptr_q) + i) % NUM_REQ;
      cand = PtrW'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    abort_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (win_found && !eng_busy) begin
          win_d   = win_idx;
          dev_d   = req_dev_addr[32'(win_idx)*7 +: 7];
          reg_d   = req_reg_addr[32'(win_idx)*8 +: 8];
          rw_d    = req_rw[win_idx];
          wdata_d = req_wdata[32'(win_idx)*8 +: 8];
          gnt_d   = NUM_REQ'(1) << win_idx;
          start_d = 1'b1;
          if (32'(win_idx) == NUM_REQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx + PtrW'(1);
          end
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        // A completion on the terminal cycle beats the timeout.
        if (eng_done) begin
          done_d[win_q] = 1'b1;
          err_d         = eng_nack;
          if (rw_q && !eng_nack) begin
            rdata_d = eng_rdata;
          end
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
          abort_d       = 1'b1;
          state_d       = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      start_q <= start_d;
      abort_q <= abort_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign eng_start    = start_q;
  assign eng_abort    = abort_q;
  assign eng_dev_addr = dev_q;
  assign eng_reg_addr = reg_q;
  assign eng_rw       = rw_q;
  assign eng_wdata    = wdata_q;

endmodule
